// File: rtl/ethernet_mdio_master.sv
// ethernet_mdio_master: IEEE 802.3 clause 22 management master.
// Turns one start request into a 32-bit preamble plus a 32-bit management
// frame on MDC/MDIO, then pulses ready for one clk.
// Optional feature macro: ETHERNET_MDIO_READ_EN (read frames and rdata).
//
// Handshake: start is a level sampled only while idle; the request fields
// (write, register, content) are captured on that same edge. busy stays high
// from the launch edge through the ready cycle; ready is a single-cycle
// completion pulse. Requests seen while busy are dropped, not queued.
module ethernet_mdio_master #(
  parameter int          CLK_DIV  = 25,
  parameter logic [4:0]  PHY_ADDR = 5'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [4:0]  register,
  input  logic [15:0] content,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        ethernet_mdc,
  inout  wire         ethernet_mdio
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DONE} state_t;

  localparam int             DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [5:0]      bit_q;      // bit index within the 64-bit sequence
  logic [31:0]     frame_q;    // ST, OP, PHYAD, REGAD, TA, DATA
  logic            mdc_q;
  logic            mdo_q;
  logic            oe_q;

  logic            tick;       // last clk of the current MDC half-period
  logic            bit_end;    // last clk of the high phase: bit finished
  logic [5:0]      next_bit;
  logic [1:0]      op_sel;
  logic            release_next;

  assign tick     = (div_q == DIV_LAST);
  assign bit_end  = tick && mdc_q;
  assign next_bit = bit_q + 6'd1;

`ifdef ETHERNET_MDIO_READ_EN
  logic        rd_frame_q;
  logic [15:0] rd_sr_q;
  logic [15:0] rdata_q;

  assign op_sel       = write ? 2'b01 : 2'b10;
  // Read frames hand MDIO to the PHY from the first TA bit (index 46) onward.
  assign release_next = rd_frame_q && (next_bit >= 6'd46);
  assign rdata        = rdata_q;

  // Read path: capture MDIO on MDC rise during the 16 data bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_frame_q <= 1'b0;
      rd_sr_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        rd_frame_q <= ~write;
        rd_sr_q    <= '0;
      end else if (state_q == FRAME && rd_frame_q && tick && !mdc_q &&
                   bit_q >= 6'd48) begin
        rd_sr_q <= {rd_sr_q[14:0], ethernet_mdio};
      end
      if (state_q == FRAME && state_d == DONE) begin
        rdata_q <= rd_sr_q;
      end
    end
  end
`else
  logic unused_write;

  assign unused_write = write;
  assign op_sel       = 2'b01;
  assign release_next = 1'b0;
  assign rdata        = 16'h0000;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: phases advance only at bit boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = PREAMBLE;
      PREAMBLE: if (bit_end && bit_q == 6'd31) state_d = FRAME;
      FRAME:    if (bit_end && bit_q == 6'd63) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign ready         = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign ethernet_mdc  = mdc_q;
  assign ethernet_mdio = oe_q ? mdo_q : 1'bz;

  // Bit engine: divider, MDC generation and MDIO drive, new bit on MDC fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      mdc_q   <= 1'b0;
      mdo_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mdc_q <= 1'b0;
          oe_q  <= 1'b0;
          if (start) begin
            frame_q <= {2'b01, op_sel, PHY_ADDR, register, 2'b10, content};
            div_q   <= '0;
            bit_q   <= '0;
            mdo_q   <= 1'b1;   // first preamble bit is on the wire at launch
            oe_q    <= 1'b1;
          end
        end
        PREAMBLE, FRAME: begin
          div_q <= tick ? '0 : div_q + 1'b1;
          if (tick && !mdc_q) begin
            mdc_q <= 1'b1;
          end
          if (bit_end) begin
            mdc_q <= 1'b0;
            bit_q <= next_bit;
            if (bit_q == 6'd63) begin
              oe_q  <= 1'b0;
              mdo_q <= 1'b0;
            end else begin
              // Bits 32..63 map to frame_q[31..0]; ~next_bit[4:0] = 63 - next_bit.
              mdo_q <= next_bit[5] ? frame_q[~next_bit[4:0]] : 1'b1;
              oe_q  <= ~release_next;
            end
          end
        end
        default: begin
          mdc_q <= 1'b0;
          oe_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_mdio_master.sv
// Testbench for ethernet_mdio_master: a CLK_DIV=2 instance for frame content
// and protocol scenarios, and a CLK_DIV=25 instance for MDC timing.
module tb_ethernet_mdio_master;

  localparam logic [4:0] PHY = 5'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (CLK_DIV=2) ----------------
  logic        start = 1'b0, write = 1'b1;
  logic [4:0]  register = '0;
  logic [15:0] content = '0;
  logic [15:0] rdata;
  logic        ready, busy, mdc;
  wire         mdio;
  logic        phy_oe = 1'b0, phy_bit = 1'b0;
  assign mdio = phy_oe ? phy_bit : 1'bz;

  ethernet_mdio_master #(.CLK_DIV(2), .PHY_ADDR(PHY)) dut (
    .clk(clk), .reset(reset), .start(start), .write(write),
    .register(register), .content(content), .rdata(rdata),
    .ready(ready), .busy(busy), .ethernet_mdc(mdc), .ethernet_mdio(mdio)
  );

  // ---------------- DUT (CLK_DIV=25) ----------------
  logic        start25 = 1'b0;
  logic [15:0] rdata25;
  logic        ready25, busy25, mdc25;
  wire         mdio25;

  ethernet_mdio_master #(.CLK_DIV(25), .PHY_ADDR(PHY)) dut25 (
    .clk(clk), .reset(reset), .start(start25), .write(1'b1),
    .register(5'h02), .content(16'h5a5a), .rdata(rdata25),
    .ready(ready25), .busy(busy25), .ethernet_mdc(mdc25), .ethernet_mdio(mdio25)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        cap_q[$];
  int          ready_cnt, busy_cnt, first_ready_cyc;
  logic [15:0] rdata_at_ready;

  // Reference: 32 ones of preamble, then ST=01, OP, PHYAD, REGAD, TA=10, DATA.
  function automatic logic [63:0] exp_frame(input logic wr, input logic [4:0] r,
                                            input logic [15:0] d);
    logic [1:0] op;
`ifdef ETHERNET_MDIO_READ_EN
    op = wr ? 2'b01 : 2'b10;
`else
    op = 2'b01;
`endif
    return {32'hFFFF_FFFF, 2'b01, op, PHY, r, 2'b10, d};
  endfunction

  function automatic logic [63:0] cap_word(input int base);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 64; i++) w[63-i] = cap_q[base+i];
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic wr, input logic [4:0] r, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; write = wr; register = r; content = d;
  endtask

  // Steps the clock after a request is presented, sampling at negedges:
  // MDIO on every observed MDC rise, busy/ready counts, optional PHY drive.
  task automatic capture(input bit hold, input int n_ready,
                         input logic [4:0] swap_reg, input logic [15:0] swap_data,
                         input int poke_cyc, input bit phy_en,
                         input logic [15:0] phy_data);
    logic prev;
    int   cyc, extra, idx;
    prev = 1'b0; cyc = 0; extra = -1;
    cap_q.delete();
    ready_cnt = 0; busy_cnt = 0; first_ready_cyc = -1; rdata_at_ready = '0;
    while (cyc < 800) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!hold && cyc == 1) start = 1'b0;
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        start = 1'b1; register = swap_reg; content = swap_data;
      end
      if (poke_cyc != 0 && cyc == poke_cyc + 3) start = 1'b0;
      if (busy) busy_cnt++;
      if (mdc && !prev) cap_q.push_back(mdio);
      if (!mdc && prev && phy_en) begin
        idx = cap_q.size();
        phy_oe  = (idx >= 47 && idx <= 63);
        phy_bit = (idx == 47) ? 1'b0 : phy_data[4'(63 - idx)];
      end
      if (ready) begin
        ready_cnt++;
        if (first_ready_cyc < 0) first_ready_cyc = cyc;
        rdata_at_ready = rdata;
        if (hold && ready_cnt == 1) begin register = swap_reg; content = swap_data; end
        if (ready_cnt == n_ready) begin start = 1'b0; extra = cyc + 10; end
      end
      prev = mdc;
      if (extra >= 0 && cyc >= extra) break;
    end
    phy_oe = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ready, busy, mdc, rdata} !== 19'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ready, busy, mdc, rdata});
    end
    n_checks++;
    if ({ready25, busy25, mdc25} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs25: got %b expected 000", {ready25, busy25, mdc25});
    end
    reset = 1'b0;
  endtask

  task automatic test_write_basic();
    logic [63:0] exp;
    exp_q.push_back(exp_frame(1'b1, 5'h04, 16'h01e1));
    drive_req(1'b1, 5'h04, 16'h01e1);
    capture(0, 1, '0, '0, 0, 0, '0);
    exp = exp_q.pop_front();
    n_checks++;
    if (cap_q.size() != 64 || cap_word(0) !== exp) begin
      n_fail++; $display("FAIL write_frame: got %0d bits %h expected %h", cap_q.size(),
                         (cap_q.size() >= 64) ? cap_word(0) : 64'h0, exp);
    end
    n_checks++;
    if (first_ready_cyc != 257) begin
      n_fail++; $display("FAIL write_ready_cycle: got %0d expected 257", first_ready_cyc);
    end
    n_checks++;
    if (busy_cnt != 257) begin
      n_fail++; $display("FAIL write_busy_cycles: got %0d expected 257", busy_cnt);
    end
    n_checks++;
    if (ready_cnt != 1) begin
      n_fail++; $display("FAIL write_ready_count: got %0d expected 1", ready_cnt);
    end
`ifndef ETHERNET_MDIO_READ_EN
    n_checks++;
    if (rdata_at_ready !== 16'h0) begin
      n_fail++; $display("FAIL rdata_tied: got %h expected 0000", rdata_at_ready);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    exp_q.push_back(exp_frame(1'b1, 5'h04, 16'h01e1));
    exp_q.push_back(exp_frame(1'b1, 5'h00, 16'h1200));
    drive_req(1'b1, 5'h04, 16'h01e1);
    capture(1, 2, 5'h00, 16'h1200, 0, 0, '0);
    n_checks++;
    if (ready_cnt != 2) begin
      n_fail++; $display("FAIL b2b_ready_count: got %0d expected 2", ready_cnt);
    end
    for (int f = 0; f < 2; f++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (cap_q.size() < 64 * (f + 1) || cap_word(64 * f) !== exp) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %0d bits %h expected %h", f, cap_q.size(),
                           (cap_q.size() >= 64 * (f + 1)) ? cap_word(64 * f) : 64'h0, exp);
      end
    end
    n_checks++;
    if (busy_cnt != 514) begin
      n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 514", busy_cnt);
    end
  endtask

`ifdef ETHERNET_MDIO_READ_EN
  task automatic test_read();
    logic [63:0] exp, got;
    exp = exp_frame(1'b0, 5'h01, 16'h0000);
    drive_req(1'b0, 5'h01, 16'hffff);
    capture(0, 1, '0, '0, 0, 1, 16'h796d);
    write = 1'b1;
    got = (cap_q.size() == 64) ? cap_word(0) : 64'h0;
    n_checks++;
    if (got[63:18] !== exp[63:18]) begin
      n_fail++; $display("FAIL read_header: got %h expected %h", got[63:18], exp[63:18]);
    end
    n_checks++;
    if (rdata_at_ready !== 16'h796d) begin
      n_fail++; $display("FAIL read_rdata: got %h expected 796d", rdata_at_ready);
    end
    n_checks++;
    if (ready_cnt != 1) begin
      n_fail++; $display("FAIL read_ready_count: got %0d expected 1", ready_cnt);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [63:0] exp;
    logic [15:0] d;
    drive_req(1'b1, 5'h0a, 16'hbeef);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (162) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mdc !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midframe_mdc_high: got mdc=%b busy=%b expected 1 1", mdc, busy);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({mdc, busy, ready} !== 3'b000) begin
      n_fail++; $display("FAIL midframe_reset: got %b expected 000", {mdc, busy, ready});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d = 16'($urandom);
    exp = exp_frame(1'b1, 5'h11, d);
    drive_req(1'b1, 5'h11, d);
    capture(0, 1, '0, '0, 0, 0, '0);
    n_checks++;
    if (cap_q.size() != 64 || cap_word(0) !== exp || first_ready_cyc != 257) begin
      n_fail++; $display("FAIL after_reset_frame: got %0d bits ready@%0d expected 64 bits %h ready@257",
                         cap_q.size(), first_ready_cyc, exp);
    end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] exp;
    exp = exp_frame(1'b1, 5'h07, 16'h3c3c);
    drive_req(1'b1, 5'h07, 16'h3c3c);
    capture(0, 1, 5'h1f, 16'hc3c3, 60, 0, '0);
    n_checks++;
    if (cap_q.size() != 64 || cap_word(0) !== exp) begin
      n_fail++; $display("FAIL busy_ignore_frame: got %0d bits %h expected %h", cap_q.size(),
                         (cap_q.size() == 64) ? cap_word(0) : 64'h0, exp);
    end
    n_checks++;
    if (ready_cnt != 1) begin
      n_fail++; $display("FAIL busy_ignore_ready_count: got %0d expected 1", ready_cnt);
    end
  endtask

  task automatic test_random_writes();
    logic [63:0] exp;
    logic        wr;
    logic [4:0]  r;
    logic [15:0] d;
    for (int n = 0; n < 4; n++) begin
`ifdef ETHERNET_MDIO_READ_EN
      wr = 1'b1;
`else
      wr = 1'($urandom_range(0, 1));
`endif
      r = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      exp_q.push_back(exp_frame(wr, r, d));
      drive_req(wr, r, d);
      capture(0, 1, '0, '0, 0, 0, '0);
      exp = exp_q.pop_front();
      n_checks++;
      if (cap_q.size() != 64 || cap_word(0) !== exp || first_ready_cyc != 257) begin
        n_fail++; $display("FAIL random_frame%0d: got %0d bits %h ready@%0d expected %h ready@257",
                           n, cap_q.size(), (cap_q.size() == 64) ? cap_word(0) : 64'h0,
                           first_ready_cyc, exp);
      end
    end
  endtask

  task automatic test_mdc_period();
    logic prev;
    int   cyc, run, bad, rises, rdy_cyc, idle_high;
    prev = 1'b0; cyc = 0; run = 0; bad = 0; rises = 0; rdy_cyc = -1; idle_high = 0;
    @(negedge clk);
    start25 = 1'b1;
    while (cyc < 4000 && rdy_cyc < 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) start25 = 1'b0;
      if (mdc25 != prev) begin
        if (run != 25) bad++;
        if (mdc25) rises++;
        run = 1;
      end else begin
        run++;
      end
      prev = mdc25;
      if (ready25) begin
        rdy_cyc = cyc;
        n_checks++;
        if (busy25 !== 1'b1) begin
          n_fail++; $display("FAIL mdc25_busy_at_ready: got %b expected 1", busy25);
        end
      end
    end
    n_checks++;
    if (rdy_cyc != 3201) begin
      n_fail++; $display("FAIL mdc25_ready_cycle: got %0d expected 3201", rdy_cyc);
    end
    n_checks++;
    if (rises != 64 || bad != 0) begin
      n_fail++; $display("FAIL mdc25_periods: got %0d rises %0d bad half-periods expected 64 0", rises, bad);
    end
    repeat (30) begin
      @(negedge clk);
      if (mdc25) idle_high++;
    end
    n_checks++;
    if (idle_high != 0) begin
      n_fail++; $display("FAIL mdc25_idle_low: got %0d high cycles expected 0", idle_high);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_basic();
    test_back_to_back();
`ifdef ETHERNET_MDIO_READ_EN
    test_read();
`endif
    test_reset_midframe();
    test_start_while_busy();
    test_random_writes();
    test_mdc_period();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
